seq_alu: RTL and testbench

- Next-generation datapath ALU: parametrised XLEN, 16 operations including RV32M-style iterative multiply/divide.
- Handshaked with valid/ready on input and output.
- Single-cycle ops complete in 1 cycle; MUL/DIV iterate over XLEN cycles.
- Sits between the register-read stage and writeback; the controller stalls on in_ready low.

---
 rtl/seq_alu_pkg.sv | 42 ++++
 rtl/seq_alu_muldiv.sv | 73 +++++++
 rtl/seq_alu.sv | 148 ++++++++++++++
 tb/tb_seq_alu.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/seq_alu_pkg.sv
// Shared types and opcode helpers for the seq_alu datapath ALU.
package seq_alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'b0000,
    OP_SUB   = 4'b0001,
    OP_AND   = 4'b0010,
    OP_OR    = 4'b0011,
    OP_XOR   = 4'b0100,
    OP_SLT   = 4'b0101,
    OP_SLTU  = 4'b0110,
    OP_SLL   = 4'b0111,
    OP_SRL   = 4'b1000,
    OP_SRA   = 4'b1001,
    OP_MUL   = 4'b1010,
    OP_MULHU = 4'b1011,
    OP_DIV   = 4'b1100,
    OP_DIVU  = 4'b1101,
    OP_REM   = 4'b1110,
    OP_REMU  = 4'b1111
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } state_t;

  function automatic logic is_iter(alu_op_t op);
    return op >= OP_MUL;
  endfunction

  function automatic logic is_div(alu_op_t op);
    return op >= OP_DIV;
  endfunction

  function automatic logic is_signed_div(alu_op_t op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/seq_alu_muldiv.sv
// One-bit-per-cycle shift-add multiplier / restoring divider sharing a hi:lo register pair.
module seq_alu_muldiv import seq_alu_pkg::*; #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            div_mode,
  input  logic [XLEN-1:0] x,
  input  logic [XLEN-1:0] y,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int CW = $clog2(XLEN);

  logic [XLEN-1:0] d_q, hi_q, lo_q, hi_n, lo_n;
  logic [CW-1:0]   cnt_q;
  logic            active_q, div_q;
  logic [XLEN:0]   sum, shifted, diff;

  // Mul: hi accumulates multiplicand x, lo shifts out multiplier y.
  // Div: lo shifts the dividend y into hi (remainder), quotient bits shift into lo.
  always_comb begin
    sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, d_q} : {(XLEN+1){1'b0}});
    shifted = {hi_q, lo_q[XLEN-1]};
    diff    = shifted - {1'b0, d_q};
    hi_n    = sum[XLEN:1];
    lo_n    = {sum[0], lo_q[XLEN-1:1]};
    if (div_q) begin
      if (!diff[XLEN]) begin
        hi_n = diff[XLEN-1:0];
        lo_n = {lo_q[XLEN-2:0], 1'b1};
      end else begin
        hi_n = shifted[XLEN-1:0];
        lo_n = {lo_q[XLEN-2:0], 1'b0};
      end
    end
  end

  assign done = active_q && (cnt_q == CW'(XLEN - 1));
  assign hi   = hi_q;
  assign lo   = lo_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
      div_q    <= 1'b0;
    end else if (start) begin
      d_q      <= x;
      hi_q     <= '0;
      lo_q     <= y;
      cnt_q    <= '0;
      active_q <= 1'b1;
      div_q    <= div_mode;
    end else if (active_q) begin
      hi_q <= hi_n;
      lo_q <= lo_n;
      if (done) begin
        active_q <= 1'b0;
        cnt_q    <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Handshaked sequential ALU: single-cycle ops plus iterative MUL/DIV via seq_alu_muldiv.
// Define SEQ_ALU_EARLY_OUT_EN to finish divide-by-zero / signed-overflow cases in one cycle.
module seq_alu import seq_alu_pkg::*; #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_op,
  input  logic [XLEN-1:0] srca,
  input  logic [XLEN-1:0] srcb,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            busy
);

  localparam int SHW = $clog2(XLEN);

  alu_op_t         op_in, op_q;
  state_t          state_q, state_d;
  logic            accept, start, load, early;
  logic            sgn, neg_a, neg_b, neg_res, div_zero, overflow, special;
  logic            neg_q, spec_q;
  logic [XLEN-1:0] mag_a, mag_b, spec_val, spec_val_q;
  logic [XLEN-1:0] simple_res, fix_sel, fix_res, next_res;
  logic [XLEN-1:0] md_hi, md_lo;
  logic            md_done;

  assign op_in    = alu_op_t'(alu_op);
  assign in_ready = (state_q == IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign busy     = (state_q != IDLE);

  // Divider runs on magnitudes; the sign and the fixed-result cases are resolved up front.
  always_comb begin
    sgn      = is_signed_div(op_in);
    neg_a    = sgn & srca[XLEN-1];
    neg_b    = sgn & srcb[XLEN-1];
    mag_a    = neg_a ? -srca : srca;
    mag_b    = neg_b ? -srcb : srcb;
    div_zero = (srcb == '0);
    overflow = sgn && (srca == {1'b1, {(XLEN-1){1'b0}}}) && (srcb == '1);
    special  = is_div(op_in) && (div_zero || overflow);
    neg_res  = (op_in == OP_DIV) ? (neg_a ^ neg_b) : neg_a;
    spec_val = '0;
    if (div_zero)
      spec_val = ((op_in == OP_DIV) || (op_in == OP_DIVU)) ? '1 : srca;
    else if (op_in == OP_DIV)
      spec_val = srca;
  end

`ifdef SEQ_ALU_EARLY_OUT_EN
  assign early = special;
`else
  assign early = 1'b0;
`endif

  assign start = accept && is_iter(op_in) && !early;

  always_comb begin
    simple_res = '0;
    case (op_in)
      OP_ADD:  simple_res = srca + srcb;
      OP_SUB:  simple_res = srca - srcb;
      OP_AND:  simple_res = srca & srcb;
      OP_OR:   simple_res = srca | srcb;
      OP_XOR:  simple_res = srca ^ srcb;
      OP_SLT:  simple_res = {{(XLEN-1){1'b0}}, $signed(srca) < $signed(srcb)};
      OP_SLTU: simple_res = {{(XLEN-1){1'b0}}, srca < srcb};
      OP_SLL:  simple_res = srca << srcb[SHW-1:0];
      OP_SRL:  simple_res = srca >> srcb[SHW-1:0];
      OP_SRA:  simple_res = $signed(srca) >>> srcb[SHW-1:0];
      default: simple_res = '0;
    endcase
  end

  seq_alu_muldiv #(.XLEN(XLEN)) u_muldiv (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .div_mode (is_div(op_in)),
    .x        (is_div(op_in) ? mag_b : srca),
    .y        (is_div(op_in) ? mag_a : srcb),
    .done     (md_done),
    .hi       (md_hi),
    .lo       (md_lo)
  );

  always_comb begin
    fix_sel = md_hi;
    if ((op_q == OP_MUL) || (op_q == OP_DIV) || (op_q == OP_DIVU))
      fix_sel = md_lo;
    fix_res = neg_q ? -fix_sel : fix_sel;
    if (spec_q)
      fix_res = spec_val_q;
  end

  assign load     = (state_q == FIX) || (accept && !start);
  assign next_res = (state_q == FIX) ? fix_res : (is_iter(op_in) ? spec_val : simple_res);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (start) state_d = is_div(op_in) ? DIV : MUL;
      MUL, DIV: if (md_done) state_d = FIX;
      FIX:      state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q       <= OP_ADD;
      neg_q      <= 1'b0;
      spec_q     <= 1'b0;
      spec_val_q <= '0;
    end else if (start) begin
      op_q       <= op_in;
      neg_q      <= neg_res;
      spec_q     <= special;
      spec_val_q <= spec_val;
    end
  end

  // A load in the same cycle as a take keeps out_valid high with the new result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b1;
    end else if (load) begin
      out_valid <= 1'b1;
      result    <= next_res;
      zero      <= (next_res == '0);
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: directed cases plus random ops against an arithmetic reference model.
module tb_seq_alu;

  localparam int XLEN = 32;
  localparam int ITER_EDGES = XLEN + 1;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      alu_op;
  logic [XLEN-1:0] srca, srcb;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;
  logic            busy;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  seq_alu #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_op    (alu_op),
    .srca      (srca),
    .srcb      (srcb),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // RISC-V M-extension semantics written directly with wide arithmetic.
  function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, sq;
    logic [63:0]     prod, sext;
    logic [31:0]     r;
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    prod = {32'b0, a} * {32'b0, b};
    r    = 32'h0;
    case (op)
      4'd0:  r = a + b;
      4'd1:  r = a - b;
      4'd2:  r = a & b;
      4'd3:  r = a | b;
      4'd4:  r = a ^ b;
      4'd5:  r = (sa < sb) ? 32'd1 : 32'd0;
      4'd6:  r = (a < b) ? 32'd1 : 32'd0;
      4'd7:  r = a << b[4:0];
      4'd8:  r = a >> b[4:0];
      4'd9:  begin sext = 64'(sa) >> b[4:0]; sext = sext | ~(64'hFFFF_FFFF_FFFF_FFFF >> b[4:0]) & {64{a[31]}}; r = sext[31:0]; end
      4'd10: r = prod[31:0];
      4'd11: r = prod[63:32];
      4'd12: begin if (b == 0) r = 32'hFFFF_FFFF; else begin sq = sa / sb; r = sq[31:0]; end end
      4'd13: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      4'd14: begin if (b == 0) r = a; else begin sq = sa % sb; r = sq[31:0]; end end
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic int expEdges(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bit special;
    bit early;
    special = (op >= 4'd12) && ((b == 0) ||
              (((op == 4'd12) || (op == 4'd14)) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)));
`ifdef SEQ_ALU_EARLY_OUT_EN
    early = 1'b1;
`else
    early = 1'b0;
`endif
    if (op >= 4'd10 && !(early && special)) return ITER_EDGES;
    return 0;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Offers one op, waits for the acceptance edge, then counts edges until out_valid.
  task automatic applyStimulus(input string tag, input logic [3:0] op, input logic [31:0] a,
                               input logic [31:0] b, output int edges, output int busy_cycles);
    int guard;
    alu_op = op; srca = a; srcb = b; in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 200) begin @(posedge clk); #1; guard++; end
    checkOutput({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; alu_op = 4'($urandom); srca = $urandom; srcb = $urandom;
    edges = 0; busy_cycles = 0;
    while (!out_valid && edges < 200) begin
      if (busy) busy_cycles++;
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic takeResult();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic runOp(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int edges, busy_cycles, exp_e;
    logic [31:0] exp_r;
    exp_r = model(op, a, b);
    exp_e = expEdges(op, a, b);
    applyStimulus(tag, op, a, b, edges, busy_cycles);
    checkOutput({tag, "_result"}, 64'(result), 64'(exp_r));
    checkOutput({tag, "_zero"}, 64'(zero), 64'(exp_r == 0));
    checkOutput({tag, "_latency"}, 64'(edges), 64'(exp_e));
    checkOutput({tag, "_busy_cycles"}, 64'(busy_cycles), 64'(exp_e));
    takeResult();
    checkOutput({tag, "_taken"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    int          edges, busy_cycles;
    bit          stable;
    logic [3:0]  op;
    logic [31:0] a, b;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    alu_op = 4'd0; srca = '0; srcb = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_result", 64'(result), 64'd0);
    checkOutput("reset_zero", 64'(zero), 64'd1);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_in_ready", 64'(in_ready), 64'd1);

    // Reset five cycles into a divide: the op must vanish without a result.
    alu_op = 4'd12; srca = 32'd100; srcb = 32'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    checkOutput("midreset_busy", 64'(busy), 64'd0);
    checkOutput("midreset_out_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1 reset = 1'b0;
    checkOutput("midreset_in_ready", 64'(in_ready), 64'd1);
    repeat (40) @(posedge clk);
    #1;
    checkOutput("midreset_no_result", 64'(out_valid), 64'd0);
    runOp("after_reset_add", 4'd0, 32'd3, 32'd4);

    runOp("sub_zero", 4'd1, 32'd5, 32'd5);
    runOp("slt", 4'd5, 32'hFFFF_FFFF, 32'd1);
    runOp("sltu", 4'd6, 32'hFFFF_FFFF, 32'd1);
    runOp("sra", 4'd9, 32'h8000_0000, 32'd4);
    runOp("mul", 4'd10, 32'h1234_5678, 32'h10);
    runOp("mulhu", 4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    runOp("div_neg", 4'd12, 32'hFFFF_FFF9, 32'd2);
    runOp("rem_neg", 4'd14, 32'hFFFF_FFF9, 32'd2);
    runOp("divu_by0", 4'd13, 32'd7, 32'd0);
    runOp("divu9_by0", 4'd13, 32'd9, 32'd0);
    runOp("div_neg_by0", 4'd12, 32'hFFFF_FFF9, 32'd0);
    runOp("rem_by0", 4'd14, 32'hFFFF_FFF9, 32'd0);
    runOp("div_ovf", 4'd12, 32'h8000_0000, 32'hFFFF_FFFF);
    runOp("rem_ovf", 4'd14, 32'h8000_0000, 32'hFFFF_FFFF);

    // Backpressure: result must hold while out_ready is low, then take/accept in one edge.
    applyStimulus("bp_add", 4'd0, 32'd20, 32'd22, edges, busy_cycles);
    checkOutput("bp_first_result", 64'(result), 64'd42);
    stable = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      if (!(out_valid && result == 32'd42 && !in_ready)) stable = 1'b0;
    end
    checkOutput("bp_stable_10_cycles", 64'(stable), 64'd1);
    alu_op = 4'd1; srca = 32'd9; srcb = 32'd2; in_valid = 1'b1;
    #1;
    checkOutput("bp_blocked_in_ready", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    #1;
    checkOutput("bp_release_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    checkOutput("bp_overlap_valid", 64'(out_valid), 64'd1);
    checkOutput("bp_overlap_result", 64'(result), 64'd7);
    takeResult();
    checkOutput("bp_final_taken", 64'(out_valid), 64'd0);

    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = $urandom;
      if (i % 7 == 3) b = 32'd0;
      if (i % 11 == 5) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      if (i % 5 == 1) b = b & 32'h0000_00FF;
      runOp($sformatf("rand%0d_op%0d", i, op), op, a, b);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
